video_in_pack_fifo: RTL and testbench

Upstream stage of the video-in store engine. It captures an 8-bit luminance pixel stream framed by frame_valid and line_valid, packs four consecutive pixels into one 32-bit word, and buffers the words in a show-ahead FIFO. The store engine consumes the FIFO through data_fifo, r_ack and nb_pack_available. Capture is armed by new_addr and covers exactly one frame of p_WIDTH*p_HEIGHT pixels.

---
 rtl/video_in_pkg.sv | 28 ++
 rtl/video_in_sync_fifo.sv | 71 +++++++
 rtl/video_in_pack_fifo.sv | 127 ++++++++++++
 tb/tb_video_in_pack_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_in_pkg.sv
// ---------------------------------------------------------------------------
// video_in_pkg
// Shared types and default geometry for the video-in capture path.
//   state_t       : capture FSM states
//   pixel_t       : 8-bit luminance sample
//   word_t        : 32-bit packed word (four pixels, first pixel in [7:0])
//   P_*_DEFAULT   : default frame geometry and FIFO threshold
// ---------------------------------------------------------------------------
package video_in_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    typedef logic [7:0]  pixel_t;
    typedef logic [31:0] word_t;

    localparam int unsigned P_WIDTH_DEFAULT       = 640;
    localparam int unsigned P_HEIGHT_DEFAULT      = 480;
    localparam int unsigned NB_PACK_STORE_DEFAULT = 16;
    localparam int unsigned FIFO_DEPTH_DEFAULT    = 64;

    localparam int unsigned FRAME_PIXELS = P_WIDTH_DEFAULT * P_HEIGHT_DEFAULT;

endpackage

// File: rtl/video_in_sync_fifo.sv
// ---------------------------------------------------------------------------
// video_in_sync_fifo
// Synchronous show-ahead FIFO of 32-bit words.
//   clk, nRST  : clock, asynchronous active-low reset
//   flush      : empty the FIFO; wins over a simultaneous push or pop
//   push       : write push_data (accepted if not full, or full with a pop)
//   push_data  : word to write
//   pop        : drop the head word (ignored when empty)
//   pop_data   : head word, valid when level != 0 (reads 0 when empty)
//   level      : number of stored words
//   full       : level == DEPTH
// ---------------------------------------------------------------------------
module video_in_sync_fifo
    import video_in_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       push,
    input  word_t                      push_data,
    input  logic                       pop,
    output word_t                      pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);

    localparam int unsigned AW = $clog2(DEPTH);

    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          pop_ok;
    logic          push_ok;

    always_comb begin
        full    = (level_q == (AW+1)'(DEPTH));
        pop_ok  = pop && (level_q != '0);
        // A full FIFO still takes a word when the head leaves in the same cycle.
        push_ok = push && (!full || pop_ok);
        level   = level_q;
        pop_data = (level_q != '0) ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/video_in_pack_fifo.sv
// ---------------------------------------------------------------------------
// video_in_pack_fifo
// Captures one frame of 8-bit pixels (framed by frame_valid/line_valid),
// packs four pixels little-endian into 32-bit words and buffers them in a
// show-ahead FIFO for the store engine.
//   clk, nRST         : clock, asynchronous active-low reset
//   new_addr          : flush everything and arm capture of the next frame
//   pixel_in          : pixel, valid when frame_valid && line_valid
//   frame_valid       : frame framing
//   line_valid        : active-pixel framing
//   r_ack             : pop the FIFO head
//   data_fifo         : FIFO head word (valid when fifo_level != 0)
//   nb_pack_available : fifo_level >= NB_PACK_STORE
//   fifo_level        : stored word count
//   overflow          : sticky, a word was dropped on a full FIFO
//   short_frame       : sticky, frame ended before all pixels arrived
// ---------------------------------------------------------------------------
module video_in_pack_fifo
    import video_in_pkg::*;
#(
    parameter int unsigned p_WIDTH       = P_WIDTH_DEFAULT,
    parameter int unsigned p_HEIGHT      = P_HEIGHT_DEFAULT,
    parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEFAULT,
    parameter int unsigned NB_PACK_STORE = NB_PACK_STORE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          nRST,
    input  logic                          new_addr,
    input  logic [7:0]                    pixel_in,
    input  logic                          frame_valid,
    input  logic                          line_valid,
    input  logic                          r_ack,
    output logic [31:0]                   data_fifo,
    output logic                          nb_pack_available,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          short_frame
);

    localparam int unsigned FRAME_PX = p_WIDTH * p_HEIGHT;
    localparam int unsigned CNT_W    = $clog2(FRAME_PX + 1);
    localparam int unsigned LW       = $clog2(FIFO_DEPTH) + 1;

    state_t             state;
    logic               fv_low_seen;
    logic [CNT_W-1:0]   pixel_cnt;
    logic [1:0]         pack_idx;
    logic [23:0]        pack_buf;

    logic               fv_edge;
    logic               accept;
    logic               last_px;
    logic               push;
    word_t              push_word;
    logic               fifo_full;

    always_comb begin
        // Rising edge of frame_valid: a low sample was seen while armed.
        fv_edge   = (state == WAIT_FRAME) && fv_low_seen && frame_valid;
        accept    = frame_valid && line_valid && ((state == CAPTURE) || fv_edge);
        last_px   = (pixel_cnt == CNT_W'(FRAME_PX - 1));
        push      = accept && (pack_idx == 2'd3);
        push_word = {pixel_in, pack_buf};
        nb_pack_available = (fifo_level >= LW'(NB_PACK_STORE));
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            fv_low_seen <= 1'b0;
            pixel_cnt   <= '0;
            pack_idx    <= '0;
            pack_buf    <= '0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else if (new_addr) begin
            state       <= WAIT_FRAME;
            fv_low_seen <= 1'b0;
            pixel_cnt   <= '0;
            pack_idx    <= '0;
            pack_buf    <= '0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            if (push && fifo_full && !r_ack) overflow <= 1'b1;

            if (accept) begin
                pixel_cnt <= pixel_cnt + CNT_W'(1);
                pack_idx  <= pack_idx + 2'd1;
                if (pack_idx != 2'd3) pack_buf[{pack_idx, 3'b000} +: 8] <= pixel_in;
            end

            case (state)
                WAIT_FRAME: begin
                    if (!frame_valid)     fv_low_seen <= 1'b1;
                    else if (fv_low_seen) state       <= CAPTURE;
                end
                CAPTURE: begin
                    if (!frame_valid) begin
                        short_frame <= 1'b1;
                        pack_idx    <= '0;
                        pack_buf    <= '0;
                        state       <= DONE;
                    end
                end
                default: ;
            endcase

            if (accept && last_px) state <= DONE;
        end
    end

    video_in_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nRST      (nRST),
        .flush     (new_addr),
        .push      (push),
        .push_data (push_word),
        .pop       (r_ack),
        .pop_data  (data_fifo),
        .level     (fifo_level),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_video_in_pack_fifo.sv
// ---------------------------------------------------------------------------
// tb_video_in_pack_fifo
// Directed bench. dut_a uses an 8x2 frame for framing/packing tests; dut_b
// uses an 8x40 frame (80 words) so the 64-word FIFO can be filled and
// overrun within one frame. Both share the pixel stream and reset; each has
// its own new_addr and r_ack.
// ---------------------------------------------------------------------------
module tb_video_in_pack_fifo;
    import video_in_pkg::*;

    logic        clk = 1'b0;
    logic        nRST;
    logic        new_addr_a, new_addr_b;
    logic        r_ack_a, r_ack_b;
    logic [7:0]  pixel_in;
    logic        frame_valid, line_valid;

    logic [31:0] data_a, data_b;
    logic        nb_a, nb_b;
    logic [6:0]  level_a, level_b;
    logic        ovf_a, ovf_b;
    logic        short_a, short_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    video_in_pack_fifo #(
        .p_WIDTH(8), .p_HEIGHT(2), .FIFO_DEPTH(64), .NB_PACK_STORE(16)
    ) dut_a (
        .clk(clk), .nRST(nRST), .new_addr(new_addr_a), .pixel_in(pixel_in),
        .frame_valid(frame_valid), .line_valid(line_valid), .r_ack(r_ack_a),
        .data_fifo(data_a), .nb_pack_available(nb_a), .fifo_level(level_a),
        .overflow(ovf_a), .short_frame(short_a)
    );

    video_in_pack_fifo #(
        .p_WIDTH(8), .p_HEIGHT(40), .FIFO_DEPTH(64), .NB_PACK_STORE(16)
    ) dut_b (
        .clk(clk), .nRST(nRST), .new_addr(new_addr_b), .pixel_in(pixel_in),
        .frame_valid(frame_valid), .line_valid(line_valid), .r_ack(r_ack_b),
        .data_fifo(data_b), .nb_pack_available(nb_b), .fifo_level(level_b),
        .overflow(ovf_b), .short_frame(short_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int v);
        logic [31:0] t;
        t = v;
        frame_valid = 1'b1;
        line_valid  = 1'b1;
        pixel_in    = t[7:0];
        tick();
    endtask

    task automatic gap();
        frame_valid = 1'b1;
        line_valid  = 1'b0;
        tick();
    endtask

    task automatic fv_low();
        frame_valid = 1'b0;
        line_valid  = 1'b0;
        tick();
    endtask

    task automatic pulse_new(input logic a, input logic b);
        new_addr_a = a;
        new_addr_b = b;
        tick();
        new_addr_a = 1'b0;
        new_addr_b = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #1;
        tests++; if (level_a !== 7'd0 || data_a !== 32'd0 || nb_a !== 1'b0 || ovf_a !== 1'b0 || short_a !== 1'b0) begin
            $display("FAIL reset_outputs_a: level=%0d data=%h nb=%b ovf=%b short=%b, required all 0", level_a, data_a, nb_a, ovf_a, short_a); fails++; end
        tests++; if (level_b !== 7'd0 || data_b !== 32'd0 || nb_b !== 1'b0 || ovf_b !== 1'b0 || short_b !== 1'b0) begin
            $display("FAIL reset_outputs_b: level=%0d data=%h nb=%b ovf=%b short=%b, required all 0", level_b, data_b, nb_b, ovf_b, short_b); fails++; end
        tests++; if (dut_a.state !== IDLE) begin
            $display("FAIL reset_state: got %0d, required IDLE", dut_a.state); fails++; end
        tick();
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_frame_8x2();
        pulse_new(1'b1, 1'b0);
        fv_low();
        for (int i = 0; i < 4; i++) px(i);
        tests++; if (level_a !== 7'd1 || data_a !== 32'h03020100) begin
            $display("FAIL first_word_latency: level=%0d head=%h, required 1 / 03020100", level_a, data_a); fails++; end
        for (int i = 4; i < 8; i++) px(i);
        gap();
        gap();
        for (int i = 8; i < 16; i++) px(i);
        tests++; if (level_a !== 7'd4) begin
            $display("FAIL frame_level: got %0d, required 4", level_a); fails++; end
        tests++; if (dut_a.state !== DONE || short_a !== 1'b0) begin
            $display("FAIL frame_done: state=%0d short=%b, required DONE / 0", dut_a.state, short_a); fails++; end
        fv_low();
        tests++; if (data_a !== 32'h03020100) begin
            $display("FAIL word0: got %h, required 03020100", data_a); fails++; end
        r_ack_a = 1'b1; tick();
        tests++; if (data_a !== 32'h07060504) begin
            $display("FAIL word1: got %h, required 07060504", data_a); fails++; end
        tick();
        tests++; if (data_a !== 32'h0B0A0908) begin
            $display("FAIL word2: got %h, required 0B0A0908", data_a); fails++; end
        tick();
        tests++; if (data_a !== 32'h0F0E0D0C || level_a !== 7'd1) begin
            $display("FAIL word3: head=%h level=%0d, required 0F0E0D0C / 1", data_a, level_a); fails++; end
        tick();
        r_ack_a = 1'b0;
        tests++; if (level_a !== 7'd0) begin
            $display("FAIL drained_level: got %0d, required 0", level_a); fails++; end
    endtask

    task automatic test_frame_active_arm();
        gap();
        frame_valid = 1'b1; line_valid = 1'b0;
        pulse_new(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) px(8'hA0 + i);
        tests++; if (level_a !== 7'd0) begin
            $display("FAIL armed_midframe_capture: level=%0d, required 0", level_a); fails++; end
        fv_low();
        for (int i = 0; i < 4; i++) px(i);
        tests++; if (level_a !== 7'd1 || data_a !== 32'h03020100) begin
            $display("FAIL next_frame_word: level=%0d head=%h, required 1 / 03020100", level_a, data_a); fails++; end
        fv_low();
    endtask

    task automatic test_threshold_overflow();
        pulse_new(1'b0, 1'b1);
        fv_low();
        for (int i = 0; i < 60; i++) px(i);
        tests++; if (level_b !== 7'd15 || nb_b !== 1'b0) begin
            $display("FAIL thresh_15: level=%0d nb=%b, required 15 / 0", level_b, nb_b); fails++; end
        for (int i = 60; i < 64; i++) px(i);
        tests++; if (level_b !== 7'd16 || nb_b !== 1'b1) begin
            $display("FAIL thresh_16: level=%0d nb=%b, required 16 / 1", level_b, nb_b); fails++; end
        r_ack_b = 1'b1; gap(); r_ack_b = 1'b0;
        tests++; if (level_b !== 7'd15 || nb_b !== 1'b0) begin
            $display("FAIL thresh_pop: level=%0d nb=%b, required 15 / 0", level_b, nb_b); fails++; end
        for (int i = 64; i < 260; i++) px(i);
        tests++; if (level_b !== 7'd64 || ovf_b !== 1'b0 || data_b !== 32'h07060504) begin
            $display("FAIL fifo_full: level=%0d ovf=%b head=%h, required 64 / 0 / 07060504", level_b, ovf_b, data_b); fails++; end
        for (int i = 260; i < 263; i++) px(i);
        r_ack_b = 1'b1; px(263); r_ack_b = 1'b0;
        tests++; if (level_b !== 7'd64 || ovf_b !== 1'b0 || data_b !== 32'h0B0A0908) begin
            $display("FAIL full_push_pop: level=%0d ovf=%b head=%h, required 64 / 0 / 0B0A0908", level_b, ovf_b, data_b); fails++; end
        for (int i = 264; i < 268; i++) px(i);
        tests++; if (level_b !== 7'd64 || ovf_b !== 1'b1 || data_b !== 32'h0B0A0908) begin
            $display("FAIL overflow_drop: level=%0d ovf=%b head=%h, required 64 / 1 / 0B0A0908", level_b, ovf_b, data_b); fails++; end
        tests++; if (nb_b !== 1'b1) begin
            $display("FAIL nb_when_full: got %b, required 1", nb_b); fails++; end
        fv_low();
    endtask

    task automatic test_short_frame();
        pulse_new(1'b1, 1'b1);
        tests++; if (level_b !== 7'd0 || ovf_b !== 1'b0 || short_b !== 1'b0) begin
            $display("FAIL new_addr_clears_b: level=%0d ovf=%b short=%b, required 0 / 0 / 0", level_b, ovf_b, short_b); fails++; end
        fv_low();
        for (int i = 0; i < 6; i++) px(i);
        fv_low();
        tests++; if (level_a !== 7'd1 || data_a !== 32'h03020100 || short_a !== 1'b1 || dut_a.state !== DONE) begin
            $display("FAIL short_frame: level=%0d head=%h short=%b state=%0d, required 1 / 03020100 / 1 / DONE", level_a, data_a, short_a, dut_a.state); fails++; end
        pulse_new(1'b1, 1'b0);
        tests++; if (level_a !== 7'd0 || short_a !== 1'b0 || ovf_a !== 1'b0 || dut_a.state !== WAIT_FRAME) begin
            $display("FAIL short_rearm: level=%0d short=%b ovf=%b state=%0d, required 0 / 0 / 0 / WAIT_FRAME", level_a, short_a, ovf_a, dut_a.state); fails++; end
    endtask

    task automatic test_reset_midframe();
        fv_low();
        for (int i = 0; i < 12; i++) px(i);
        tests++; if (level_a !== 7'd3 || dut_a.state !== CAPTURE) begin
            $display("FAIL pre_reset: level=%0d state=%0d, required 3 / CAPTURE", level_a, dut_a.state); fails++; end
        nRST = 1'b0;
        #1;
        tests++; if (level_a !== 7'd0 || data_a !== 32'd0 || nb_a !== 1'b0 || ovf_a !== 1'b0 || short_a !== 1'b0 || dut_a.state !== IDLE) begin
            $display("FAIL midframe_reset: level=%0d data=%h nb=%b ovf=%b short=%b state=%0d, required all 0 / IDLE", level_a, data_a, nb_a, ovf_a, short_a, dut_a.state); fails++; end
        tick();
        nRST = 1'b1;
        fv_low();
        for (int i = 0; i < 4; i++) px(i);
        fv_low();
        tests++; if (level_a !== 7'd0 || dut_a.state !== IDLE) begin
            $display("FAIL idle_ignores: level=%0d state=%0d, required 0 / IDLE", level_a, dut_a.state); fails++; end
        r_ack_a = 1'b1; tick(); r_ack_a = 1'b0;
        tests++; if (level_a !== 7'd0 || ovf_a !== 1'b0) begin
            $display("FAIL empty_pop: level=%0d ovf=%b, required 0 / 0", level_a, ovf_a); fails++; end
        pulse_new(1'b1, 1'b0);
        fv_low();
        for (int i = 16; i < 20; i++) px(i);
        tests++; if (level_a !== 7'd1 || data_a !== 32'h13121110) begin
            $display("FAIL resume_after_reset: level=%0d head=%h, required 1 / 13121110", level_a, data_a); fails++; end
        fv_low();
    endtask

    initial begin
        nRST        = 1'b0;
        new_addr_a  = 1'b0;
        new_addr_b  = 1'b0;
        r_ack_a     = 1'b0;
        r_ack_b     = 1'b0;
        pixel_in    = 8'h00;
        frame_valid = 1'b0;
        line_valid  = 1'b0;

        test_reset();
        test_frame_8x2();
        test_frame_active_arm();
        test_threshold_overflow();
        test_short_frame();
        test_reset_midframe();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
